// File: rtl/gbc_line_buffer.sv
// gbc_line_buffer: ping-pong scanline buffer between the PPU color file and
// the display/scaler side. RGB555 pixels are written at the PPU rate into one
// bank while the other bank drains as RGB888 over a valid/ready handshake.
// Optional macro LINE_BUFFER_DROP_CNT_EN enables the saturating dropped-pixel
// counter on O_DROP_CNT; without it O_DROP_CNT is constant zero.
module gbc_line_buffer #(
    parameter int LINE_WIDTH = 160,
    parameter int XW         = 8
) (
    input  logic          I_CLK,
    input  logic          I_RESET,
    input  logic          I_FRAME_START,
    input  logic          I_PIX_VALID,
    input  logic [15:0]   I_PIX_COLOR,
    output logic          O_PIX_READY,
    output logic          O_RGB_VALID,
    input  logic          I_RGB_READY,
    output logic [7:0]    O_RGB_R,
    output logic [7:0]    O_RGB_G,
    output logic [7:0]    O_RGB_B,
    output logic [XW-1:0] O_RGB_X,
    output logic          O_RGB_LAST,
    output logic [7:0]    O_DROP_CNT
);
    localparam int AW = XW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_OUT} rstate_t;

    logic [14:0]   mem [2*LINE_WIDTH];
    logic [14:0]   rd_data;
    logic [1:0]    full, full_nxt;
    logic          wb, rb, rb_nxt;
    logic [XW-1:0] wp, rp, rp_nxt, rd_col;
    logic [AW-1:0] waddr, raddr;
    rstate_t       state, state_nxt;
    logic          accept, wr_last, hs, hs_last, load;

    // Bit 15 of the color word carries no information.
    logic unused_bit15;
    assign unused_bit15 = I_PIX_COLOR[15];

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign O_PIX_READY = ~full[wb];
    assign accept  = I_PIX_VALID & O_PIX_READY & ~I_FRAME_START & ~I_RESET;
    assign wr_last = accept & (wp == X_LAST);
    assign hs      = O_RGB_VALID & I_RGB_READY;
    assign hs_last = hs & O_RGB_LAST;
    assign waddr   = wb ? (AW'(LINE_WIDTH) + AW'(wp)) : AW'(wp);

    // Read FSM next state; the RAM address always targets the pixel that
    // must be sitting in rd_data next cycle, which gives 1 pixel/cycle.
    always_comb begin
        state_nxt = state;
        rb_nxt    = rb;
        rp_nxt    = rp;
        load      = 1'b0;
        full_nxt  = full;
        if (wr_last) full_nxt[wb] = 1'b1;
        if (hs_last) full_nxt[rb] = 1'b0;
        case (state)
            R_IDLE: begin
                rp_nxt = '0;
                // A bank completing this very cycle counts as full, so the
                // first output appears two cycles after the last write.
                if (full[rb] | (wr_last & (wb == rb))) state_nxt = R_LOAD;
            end
            R_LOAD: begin
                load      = 1'b1;
                state_nxt = R_OUT;
            end
            R_OUT: begin
                if (hs_last) begin
                    rb_nxt    = ~rb;
                    rp_nxt    = '0;
                    state_nxt = (full[~rb] | (wr_last & (wb == ~rb))) ? R_LOAD : R_IDLE;
                end else if (hs) begin
                    rp_nxt = rp + XW'(1);
                    load   = 1'b1;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
        if (I_FRAME_START) begin
            state_nxt = R_IDLE;
            rb_nxt    = 1'b0;
            rp_nxt    = '0;
            load      = 1'b0;
        end
        rd_col = (state_nxt == R_OUT && rp_nxt != X_LAST) ? rp_nxt + XW'(1) : rp_nxt;
        raddr  = rb_nxt ? (AW'(LINE_WIDTH) + AW'(rd_col)) : AW'(rd_col);
    end

    // Line storage: write port from the PPU, registered read port for drain.
    always_ff @(posedge I_CLK) begin
        if (accept) mem[waddr] <= I_PIX_COLOR[14:0];
        rd_data <= mem[raddr];
    end

    // Bank flags, pointers, FSM state and registered RGB outputs.
    always_ff @(posedge I_CLK) begin
        if (I_RESET || I_FRAME_START) begin
            full        <= '0;
            wb          <= 1'b0;
            wp          <= '0;
            rb          <= 1'b0;
            rp          <= '0;
            state       <= R_IDLE;
            O_RGB_VALID <= 1'b0;
            O_RGB_X     <= '0;
            O_RGB_LAST  <= 1'b0;
            if (I_RESET) begin
                O_RGB_R <= '0;
                O_RGB_G <= '0;
                O_RGB_B <= '0;
            end
        end else begin
            full  <= full_nxt;
            state <= state_nxt;
            rb    <= rb_nxt;
            rp    <= rp_nxt;
            if (accept) begin
                wp <= wr_last ? '0 : wp + XW'(1);
                if (wr_last) wb <= ~wb;
            end
            if (load) begin
                O_RGB_VALID <= 1'b1;
                O_RGB_R     <= expand5(rd_data[4:0]);
                O_RGB_G     <= expand5(rd_data[9:5]);
                O_RGB_B     <= expand5(rd_data[14:10]);
                O_RGB_X     <= rp_nxt;
                O_RGB_LAST  <= (rp_nxt == X_LAST);
            end else if (hs_last) begin
                O_RGB_VALID <= 1'b0;
                O_RGB_LAST  <= 1'b0;
            end
        end
    end

`ifdef LINE_BUFFER_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of pixels discarded while the write bank is full.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) drop_cnt <= '0;
        else if (I_PIX_VALID && !O_PIX_READY && !I_FRAME_START && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

    assign O_DROP_CNT = drop_cnt;
`else
    assign O_DROP_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_gbc_line_buffer.sv
// Scoreboard bench for gbc_line_buffer: accepted pixels push their expected
// RGB888 output into a queue; a monitor pops on each output handshake.
module tb_gbc_line_buffer;
    localparam int LW = 160;
    localparam int XW = 8;

    logic          clk = 1'b0;
    logic          rst, frame_start, pix_valid, pix_ready;
    logic [15:0]   pix_color;
    logic          rgb_valid, rgb_ready, rgb_last;
    logic [7:0]    rgb_r, rgb_g, rgb_b, drop_cnt;
    logic [XW-1:0] rgb_x;

    always #5 clk = ~clk;

    gbc_line_buffer #(.LINE_WIDTH(LW), .XW(XW)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_FRAME_START(frame_start),
        .I_PIX_VALID(pix_valid), .I_PIX_COLOR(pix_color), .O_PIX_READY(pix_ready),
        .O_RGB_VALID(rgb_valid), .I_RGB_READY(rgb_ready),
        .O_RGB_R(rgb_r), .O_RGB_G(rgb_g), .O_RGB_B(rgb_b),
        .O_RGB_X(rgb_x), .O_RGB_LAST(rgb_last), .O_DROP_CNT(drop_cnt)
    );

    typedef struct packed {
        logic [7:0] r, g, b;
        logic [7:0] x;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, errs = 0;
    int   completed = 0, freed = 0, wcount = 0, drops = 0;
    bit   chk_en = 0;

    // 5-bit to 8-bit: scale by 8 and fill the low bits with the top bits.
    function automatic logic [7:0] ex(input int c);
        return 8'((c * 8) + (c / 4));
    endfunction

    function automatic int exp_drop();
`ifdef LINE_BUFFER_DROP_CNT_EN
        return drops;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Write-side model: a line-level view of how many complete lines are
    // waiting (at most two fit), plus the drop count.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pix_ready", int'(pix_ready), int'((completed - freed) < 2));
            chk("drop_cnt", int'(drop_cnt), exp_drop());
        end
        if (rst) begin
            q.delete(); completed = 0; freed = 0; wcount = 0; drops = 0;
        end else if (frame_start) begin
            q.delete(); completed = 0; freed = 0; wcount = 0;
        end else if (pix_valid) begin
            if (completed - freed < 2) begin
                q.push_back('{r: ex(int'(pix_color[4:0])), g: ex(int'(pix_color[9:5])),
                              b: ex(int'(pix_color[14:10])), x: 8'(wcount),
                              last: (wcount == LW - 1)});
                wcount++;
                if (wcount == LW) begin
                    wcount = 0;
                    completed++;
                end
            end else if (drops < 255) begin
                drops++;
            end
        end
    end

    // Output monitor: whatever is presented must be the queue head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (chk_en && !rst && !frame_start && rgb_valid) begin
            vectors++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL spurious_valid: got x=%0d with nothing expected", rgb_x);
            end else begin
                e = q[0];
                if (rgb_r !== e.r || rgb_g !== e.g || rgb_b !== e.b ||
                    rgb_x !== e.x || rgb_last !== e.last) begin
                    errs++;
                    $display("FAIL pixel: got rgb=%h%h%h x=%0d last=%b expected rgb=%h%h%h x=%0d last=%b",
                             rgb_r, rgb_g, rgb_b, rgb_x, rgb_last, e.r, e.g, e.b, e.x, e.last);
                end
                if (rgb_ready) begin
                    void'(q.pop_front());
                    if (e.last) freed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [15:0] c);
        pix_valid = 1'b1;
        pix_color = c;
        tick();
    endtask

    task automatic wait_drain(input int bound, output int n);
        n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; frame_start = 0; pix_valid = 0; pix_color = '0; rgb_ready = 0;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk("rst_valid", int'(rgb_valid), 0);
        chk("rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 0);
        chk("rst_x", int'(rgb_x), 0);
        chk("rst_last", int'(rgb_last), 0);
        chk("rst_ready", int'(pix_ready), 1);
        chk("rst_drop", int'(drop_cnt), 0);
        chk_en = 1;
        tick();

        // White line, consumer always ready; check first-output latency.
        rgb_ready = 1;
        for (int i = 0; i < LW; i++) push_pix(16'h7FFF);
        pix_valid = 0;
        @(negedge clk);
        chk("latency_n1_valid", int'(rgb_valid), 0);
        @(negedge clk);
        chk("latency_n2_valid", int'(rgb_valid), 1);
        wait_drain(400, n);

        // Color equals column, consumer stalled for a while.
        rgb_ready = 0;
        for (int i = 0; i < LW; i++) push_pix(16'(i));
        pix_valid = 0;
        repeat (20) tick();
        rgb_ready = 1;
        wait_drain(400, n);

        // Three lines with consumer stalled: third line is dropped.
        rgb_ready = 0;
        for (int i = 0; i < 3 * LW; i++) push_pix(16'($urandom));
        pix_valid = 0;
        @(negedge clk);
        chk("overrun_ready", int'(pix_ready), 0);
`ifdef LINE_BUFFER_DROP_CNT_EN
        chk("overrun_drops", int'(drop_cnt), 160);
`else
        chk("overrun_drops", int'(drop_cnt), 0);
`endif
        tick();
        rgb_ready = 1;
        wait_drain(400, n);
        chk("two_line_drain_le_322", int'(n <= 322), 1);

        // Frame start while one line drains and another fills.
        rgb_ready = 0;
        for (int i = 0; i < LW; i++) push_pix(16'($urandom));
        for (int i = 0; i < 80; i++) begin
            if (i == 30) rgb_ready = 1;
            push_pix(16'($urandom));
        end
        frame_start = 1;
        push_pix(16'($urandom));
        frame_start = 0;
        pix_valid = 0;
        @(negedge clk);
        chk("fs_valid", int'(rgb_valid), 0);
        chk("fs_ready", int'(pix_ready), 1);
        tick();
        for (int i = 0; i < LW; i++) push_pix(16'($urandom));
        pix_valid = 0;
        wait_drain(400, n);

        // Long overrun saturates the drop counter; frame start keeps it.
        rgb_ready = 0;
        for (int i = 0; i < 2 * LW + 300; i++) push_pix(16'($urandom));
        pix_valid = 0;
        frame_start = 1;
        tick();
        frame_start = 0;
        @(negedge clk);
`ifdef LINE_BUFFER_DROP_CNT_EN
        chk("drop_saturated", int'(drop_cnt), 255);
`else
        chk("drop_saturated", int'(drop_cnt), 0);
`endif
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("drop_after_reset", int'(drop_cnt), 0);
        tick();

        // Random traffic with bursty producer and random back-pressure.
        for (int i = 0; i < 1500; i++) begin
            pix_valid = ($urandom_range(3) != 0);
            pix_color = 16'($urandom);
            rgb_ready = ($urandom_range(2) != 0);
            tick();
        end
        rgb_ready = 1;
        n = 0;
        while (wcount != 0 && n < 2000) begin
            push_pix(16'($urandom));
            n++;
        end
        pix_valid = 0;
        chk("random_line_closed", wcount, 0);
        wait_drain(800, n);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
